// File: rtl/cal_engine_ctrl.sv
// cal_engine_ctrl
// Runs one add, subtract or shift-add multiply for each accepted start from the
// cal_start register. Results and status go back to the status register block.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   start_en, start_wr   start field level and its write strobe (start = both high)
//   op_a, op_b           unsigned operands, sampled only at start
//   op_code              0 add, 1 sub, 2 mul, 3 invalid; sampled only at start
//   done_clr             one-cycle clear of the sticky done / err / ovr flags
//   busy                 operation in progress (state != IDLE)
//   done, done_pulse     sticky completion flag and one-cycle completion strobe
//   err                  sticky flag: invalid opcode launched
//   ovr                  sticky flag: start seen while busy
//   result               result of the last completed operation, 2*DATA_WIDTH bits
//   cal_cnt              completed-operation count (invalid ops included), wraps
//
// State | meaning
// IDLE  | waiting for start; operands and opcode latched on start
// CALC  | add/sub for one cycle, or DATA_WIDTH shift-add multiply steps
// FIN   | result valid, done_pulse high; returns to IDLE next cycle

module cal_engine_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_en,
  input  logic                    start_wr,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  input  logic [1:0]              op_code,
  input  logic                    done_clr,
  output logic                    busy,
  output logic                    done,
  output logic                    done_pulse,
  output logic                    err,
  output logic                    ovr,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic [CNT_WIDTH-1:0]    cal_cnt
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_INV = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [1:0]              op_q;
  logic [2*DATA_WIDTH-1:0] acc_q;
  logic [BW-1:0]           bit_cnt_q;
  logic                    done_q;
  logic                    done_pulse_q;
  logic                    err_q;
  logic                    ovr_q;
  logic [2*DATA_WIDTH-1:0] result_q;
  logic [CNT_WIDTH-1:0]    cnt_q;

  logic                    start;
  logic [DATA_WIDTH-1:0]   mul_addend_d;
  logic [DATA_WIDTH:0]     mul_sum_d;
  logic [2*DATA_WIDTH-1:0] mul_acc_d;
  logic [DATA_WIDTH:0]     addsub_d;
  logic [2*DATA_WIDTH-1:0] addsub_res_d;

  assign start = start_wr & start_en;

  // The multiplier sits in the low half of acc_q and is shifted out as the
  // partial product grows into the upper half. The subtract is done one bit
  // wider than the operands so the top bit is the borrow.
  always_comb begin
    mul_addend_d = acc_q[0] ? a_q : '0;
    mul_sum_d    = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, mul_addend_d};
    mul_acc_d    = {mul_sum_d, acc_q[DATA_WIDTH-1:1]};
    if (op_q == OP_SUB) begin
      addsub_d = {1'b0, a_q} - {1'b0, b_q};
    end else begin
      addsub_d = {1'b0, a_q} + {1'b0, b_q};
    end
    addsub_res_d = {{(DATA_WIDTH-1){1'b0}}, addsub_d};
  end

  // Clears are written before sets so that a same-cycle set takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      acc_q        <= '0;
      bit_cnt_q    <= '0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      err_q        <= 1'b0;
      ovr_q        <= 1'b0;
      result_q     <= '0;
      cnt_q        <= '0;
    end else begin
      done_pulse_q <= 1'b0;
      if (done_clr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (start && (state_q != S_IDLE)) begin
        ovr_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q       <= op_a;
            b_q       <= op_b;
            op_q      <= op_code;
            acc_q     <= {{DATA_WIDTH{1'b0}}, op_b};
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            if (op_code == OP_INV) begin
              // Invalid opcode skips CALC and completes immediately with result 0.
              state_q      <= S_FIN;
              err_q        <= 1'b1;
              done_q       <= 1'b1;
              done_pulse_q <= 1'b1;
              result_q     <= '0;
              cnt_q        <= cnt_q + CNT_WIDTH'(1);
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (op_q == OP_MUL) begin
            acc_q     <= mul_acc_d;
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_q      <= S_FIN;
              result_q     <= mul_acc_d;
              done_q       <= 1'b1;
              done_pulse_q <= 1'b1;
              cnt_q        <= cnt_q + CNT_WIDTH'(1);
            end
          end else begin
            state_q      <= S_FIN;
            result_q     <= addsub_res_d;
            done_q       <= 1'b1;
            done_pulse_q <= 1'b1;
            cnt_q        <= cnt_q + CNT_WIDTH'(1);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign done_pulse = done_pulse_q;
  assign err        = err_q;
  assign ovr        = ovr_q;
  assign result     = result_q;
  assign cal_cnt    = cnt_q;

endmodule

// File: tb/tb_cal_engine_ctrl.sv
// tb_cal_engine_ctrl
// Directed bench for cal_engine_ctrl. Inputs change and outputs are checked on
// the falling edge. "Cn" in the comments is the cycle that begins at the nth
// rising edge after the rising edge that samples the start (C0).

module tb_cal_engine_ctrl;

  localparam int DW = 32;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_en;
  logic            start_wr;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic [1:0]      op_code;
  logic            done_clr;
  logic            busy;
  logic            done;
  logic            done_pulse;
  logic            err;
  logic            ovr;
  logic [2*DW-1:0] result;
  logic [CW-1:0]   cal_cnt;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  cal_engine_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_en(start_en), .start_wr(start_wr),
    .op_a(op_a), .op_b(op_b), .op_code(op_code), .done_clr(done_clr),
    .busy(busy), .done(done), .done_pulse(done_pulse), .err(err), .ovr(ovr),
    .result(result), .cal_cnt(cal_cnt)
  );

  always #5 clk = ~clk;

  // Issue a one-cycle start strobe in the current cycle (C0); returns in C1.
  task automatic start_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] op);
    op_a = a; op_b = b; op_code = op; start_en = 1'b1; start_wr = 1'b1;
    @(negedge clk);
    start_wr = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (done_pulse !== 1'b0) begin errors++; $display("FAIL reset_done_pulse: got %b expected 0", done_pulse); end
    checks++; if (err !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL reset_err_ovr: got err=%b ovr=%b expected 0 0", err, ovr); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (cal_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", cal_cnt); end
  endtask

  task automatic test_add;
    start_op(32'hFFFF_FFFF, 32'h1, 2'd0);
    exp_cnt = exp_cnt + 16'd1;
    // C1: CALC
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_c1_busy: got %b expected 1", busy); end
    checks++; if (done_pulse !== 1'b0) begin errors++; $display("FAIL add_c1_pulse: got %b expected 0", done_pulse); end
    @(negedge clk); // C2: FIN
    checks++; if (done_pulse !== 1'b1) begin errors++; $display("FAIL add_c2_pulse: got %b expected 1", done_pulse); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_c2_busy: got %b expected 1", busy); end
    checks++; if (result !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL add_result: got %h expected 0000000100000000", result); end
    checks++; if (cal_cnt !== exp_cnt) begin errors++; $display("FAIL add_cnt: got %h expected %h", cal_cnt, exp_cnt); end
    @(negedge clk); // C3: IDLE
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_c3_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b1 || done_pulse !== 1'b0) begin errors++; $display("FAIL add_c3_flags: got done=%b pulse=%b expected 1 0", done, done_pulse); end
  endtask

  task automatic test_sub;
    start_op(32'd3, 32'd5, 2'd1);
    exp_cnt = exp_cnt + 16'd1;
    // Operand changes after the start must not disturb the operation.
    op_a = 32'hFFFF_FFFF; op_b = 32'h0; op_code = 2'd2;
    @(negedge clk); // C2
    checks++; if (done_pulse !== 1'b1) begin errors++; $display("FAIL sub_pulse: got %b expected 1", done_pulse); end
    checks++; if (result !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL sub_result: got %h expected 00000001fffffffe", result); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || cal_cnt !== exp_cnt) begin errors++; $display("FAIL sub_end: got busy=%b cnt=%h expected 0 %h", busy, cal_cnt, exp_cnt); end
  endtask

  task automatic test_mul;
    int n;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2);
    exp_cnt = exp_cnt + 16'd1;
    op_a = 32'h0; op_b = 32'h0;
    n = 1;
    while (done_pulse !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 33) begin errors++; $display("FAIL mul_latency: got %0d cycles expected 33", n); end
    checks++; if (result !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL mul_result_max: got %h expected fffffffe00000001", result); end
    checks++; if (cal_cnt !== exp_cnt) begin errors++; $display("FAIL mul_cnt: got %h expected %h", cal_cnt, exp_cnt); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_idle: got busy=%b expected 0", busy); end

    start_op(32'hFFFF_FFFF, 32'd2, 2'd2);
    exp_cnt = exp_cnt + 16'd1;
    repeat (32) @(negedge clk); // C33
    checks++; if (done_pulse !== 1'b1 || result !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL mul_result_x2: got pulse=%b result=%h expected 1 00000001fffffffe", done_pulse, result); end
    @(negedge clk);
  endtask

  task automatic test_ovr;
    start_op(32'h0001_0000, 32'h0003_0005, 2'd2);
    exp_cnt = exp_cnt + 16'd1;
    repeat (4) @(negedge clk); // C5
    op_a = 32'd1; op_b = 32'd1; op_code = 2'd0; start_wr = 1'b1;
    @(negedge clk); // C6
    start_wr = 1'b0;
    checks++; if (ovr !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ovr_set: got ovr=%b busy=%b expected 1 1", ovr, busy); end
    repeat (26) @(negedge clk); // C32: last CALC cycle
    checks++; if (done_pulse !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ovr_early_done: got pulse=%b done=%b expected 0 0", done_pulse, done); end
    done_clr = 1'b1;
    @(negedge clk); // C33: FIN entered on the same edge as the clear
    done_clr = 1'b0;
    checks++; if (done !== 1'b1 || done_pulse !== 1'b1) begin errors++; $display("FAIL clr_vs_set_done: got done=%b pulse=%b expected 1 1", done, done_pulse); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL clr_ovr: got %b expected 0", ovr); end
    checks++; if (result !== 64'h0000_0003_0005_0000) begin errors++; $display("FAIL ovr_result: got %h expected 0000000300050000", result); end
    checks++; if (cal_cnt !== exp_cnt) begin errors++; $display("FAIL ovr_cnt: got %h expected %h", cal_cnt, exp_cnt); end
    // Start during FIN together with a clear: ovr set wins, done clears.
    start_wr = 1'b1; done_clr = 1'b1;
    @(negedge clk); // C34
    start_wr = 1'b0; done_clr = 1'b0;
    checks++; if (ovr !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL fin_start_ovr: got ovr=%b done=%b expected 1 0", ovr, done); end
    checks++; if (busy !== 1'b0 || cal_cnt !== exp_cnt) begin errors++; $display("FAIL fin_start_ignored: got busy=%b cnt=%h expected 0 %h", busy, cal_cnt, exp_cnt); end
    done_clr = 1'b1;
    @(negedge clk);
    done_clr = 1'b0;
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", ovr); end
  endtask

  task automatic test_ignored_start;
    op_a = 32'd9; op_b = 32'd9; op_code = 2'd0; start_en = 1'b0; start_wr = 1'b1;
    @(negedge clk);
    start_wr = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_busy: got %b expected 0", busy); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (cal_cnt !== exp_cnt || done_pulse !== 1'b0) begin errors++; $display("FAIL ignored_cnt: got cnt=%h pulse=%b expected %h 0", cal_cnt, done_pulse, exp_cnt); end
    start_en = 1'b1;
  endtask

  task automatic test_invalid;
    start_op(32'd5, 32'd6, 2'd3);
    exp_cnt = exp_cnt + 16'd1;
    // C1 is FIN already
    checks++; if (err !== 1'b1 || done !== 1'b1 || done_pulse !== 1'b1) begin errors++; $display("FAIL inv_flags: got err=%b done=%b pulse=%b expected 1 1 1", err, done, done_pulse); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL inv_result: got %h expected 0", result); end
    checks++; if (busy !== 1'b1 || cal_cnt !== exp_cnt) begin errors++; $display("FAIL inv_busy_cnt: got busy=%b cnt=%h expected 1 %h", busy, cal_cnt, exp_cnt); end
    @(negedge clk); // C2
    checks++; if (busy !== 1'b0 || done_pulse !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL inv_c2: got busy=%b pulse=%b err=%b expected 0 0 1", busy, done_pulse, err); end
    done_clr = 1'b1;
    @(negedge clk);
    done_clr = 1'b0;
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL inv_clear: got done=%b err=%b expected 0 0", done, err); end
  endtask

  task automatic test_back_to_back;
    start_op(32'd10, 32'd20, 2'd0);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk); // C2
    checks++; if (done_pulse !== 1'b1 || result !== 64'd30) begin errors++; $display("FAIL b2b_first: got pulse=%b result=%h expected 1 1e", done_pulse, result); end
    @(negedge clk); // C3: IDLE, start again immediately
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got busy=%b expected 0", busy); end
    start_op(32'd100, 32'd1, 2'd1);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy=%b done=%b ovr=%b expected 1 0 0", busy, done, ovr); end
    @(negedge clk);
    checks++; if (done_pulse !== 1'b1 || result !== 64'd99 || cal_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_second: got pulse=%b result=%h cnt=%h expected 1 63 %h", done_pulse, result, cal_cnt, exp_cnt); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2);
    @(negedge clk); // C2
    start_wr = 1'b1; // sets ovr so reset has a sticky flag to clear
    @(negedge clk); // C3
    start_wr = 1'b0;
    repeat (7) @(negedge clk); // C10
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || done_pulse !== 1'b0 || err !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got busy=%b done=%b pulse=%b err=%b ovr=%b expected all 0", busy, done, done_pulse, err, ovr); end
    checks++; if (result !== 64'h0 || cal_cnt !== 16'h0) begin errors++; $display("FAIL rst_mid_data: got result=%h cnt=%h expected 0 0", result, cal_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    start_op(32'd1, 32'd2, 2'd0);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    checks++; if (done_pulse !== 1'b1 || result !== 64'd3 || cal_cnt !== exp_cnt) begin errors++; $display("FAIL rst_mid_after: got pulse=%b result=%h cnt=%h expected 1 3 %h", done_pulse, result, cal_cnt, exp_cnt); end
    @(negedge clk);
  endtask

  task automatic test_cnt_wrap;
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    checks++; if (cal_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", cal_cnt); end
    start_op(32'd7, 32'd8, 2'd0);
    @(negedge clk);
    checks++; if (cal_cnt !== 16'h0000 || result !== 64'd15) begin errors++; $display("FAIL wrap_cnt: got cnt=%h result=%h expected 0000 f", cal_cnt, result); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start_en = 1'b0; start_wr = 1'b0; done_clr = 1'b0;
    op_a = '0; op_b = '0; op_code = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_ovr();
    test_ignored_start();
    test_invalid();
    test_back_to_back();
    test_reset_mid_op();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cal_engine_ctrl.md
# cal_engine_ctrl

Calculation engine controller that sits directly downstream of the cal_start control register. It consumes the start-enable field value and its one-cycle write strobe and launches one arithmetic operation per start. Supported operations are add, subtract, and sequential shift-add multiply on two operands held in the operand registers. It returns busy, done, error, overrun, result and a completion count to the status register block.

## Interface
Parameters:
- DATA_WIDTH, 32, operand width; result is 2*DATA_WIDTH.
- CNT_WIDTH, 16, completion counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_en  in  1  level value of the start-enable field.
- start_wr  in  1  one-cycle strobe, high the cycle after a start-register write.
- op_a  in  DATA_WIDTH  operand A, unsigned.
- op_b  in  DATA_WIDTH  operand B, unsigned.
- op_code  in  2  operation select: 0 add, 1 sub, 2 mul, 3 invalid.
- done_clr  in  1  one-cycle pulse that clears the sticky done, err and ovr flags.
- busy  out  1  high while an operation is in progress.
- done  out  1  sticky completion flag.
- done_pulse  out  1  one-cycle completion strobe.
- err  out  1  sticky flag; set when the invalid opcode is launched.
- ovr  out  1  sticky flag; set when a start arrives while busy.
- result  out  2*DATA_WIDTH  result of the last operation, registered.
- cal_cnt  out  CNT_WIDTH  count of completed operations, including invalid ones.

## Operation
- Start condition: start = start_wr & start_en. A start_wr with start_en=0 is ignored and changes no state.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - On start: latch op_a, op_b and op_code; clear done and err; go to CALC.
  - If the latched op_code is 3, go to FIN instead, set err, and load result=0.
- CALC, add/sub: one cycle, then go to FIN.
- CALC, mul: DATA_WIDTH cycles, then go to FIN.
  - Each cycle: if multiplier bit 0 is 1, add the multiplicand to the accumulator's upper half; then shift right by 1. This is standard shift-add.
  - An internal bit counter runs from 0 to DATA_WIDTH-1.
- FIN: one cycle, then go to IDLE.
- Add: result = {zeros, carry, a+b}; that is, a (DATA_WIDTH+1)-bit sum, zero-extended.
- Sub: result[DATA_WIDTH-1:0] = (a-b) mod 2^DATA_WIDTH; result[DATA_WIDTH] = borrow (a<b); upper bits are 0.
- Mul: result = full unsigned 2*DATA_WIDTH-bit product.
- Operand and opcode inputs are sampled only at start. Later changes to them have no effect on the operation in progress.
- Start while busy (state != IDLE): the start is ignored, ovr is set, and the operation in progress is unaffected.
- done_clr clears done, err and ovr.
  - If done_clr and a set condition occur in the same cycle, the set wins.
  - A start in IDLE also clears done and err, but not ovr.
- cal_cnt increments by 1 on the edge entering FIN and wraps from all-ones to 0.
- Reset, including mid-operation: state=IDLE; busy, done, done_pulse, err, ovr = 0; result = 0; cal_cnt = 0. The internal accumulator and counter are cleared.

## Timing
- Cycle numbering: C0 = cycle in which start is sampled.
- busy = (state != IDLE), decoded from the registered state. It is high from C1 through the FIN cycle.
- Add/sub:
  - C1 is CALC and C2 is FIN.
  - result, done and cal_cnt update on the C1→C2 edge.
  - done_pulse is high in C2; busy is low from C3.
- Mul:
  - CALC occupies C1..C(DATA_WIDTH) and FIN is C(DATA_WIDTH+1).
  - Latency from start to done_pulse is DATA_WIDTH+1 cycles.
- Invalid opcode: FIN in C1; err, done and done_pulse are visible in C1.
- Back-to-back: a start in the cycle right after FIN (state IDLE) is accepted. A start during FIN sets ovr.
- result holds its value until the next operation completes.

## Test plan
- Add: a=0xFFFF_FFFF, b=1, op=0. Expect result=0x1_0000_0000; done_pulse in C2; busy high for C1–C2; cal_cnt=1.
- Sub: a=3, b=5, op=1. Expect result[31:0]=0xFFFF_FFFE and result[32]=1. Mul: a=0xFFFF_FFFF, b=0xFFFF_FFFF, op=2. Expect result=0xFFFF_FFFE_0000_0001 and done_pulse exactly 33 cycles after start.
- Start during mul (cycle C5) → ovr=1, and the original product is unchanged. Then done_clr together with a completing FIN → done remains 1, and ovr clears only if it is not being set that cycle.
- start_wr=1 with start_en=0 → no busy and no count change. op=3 → err=1, done=1, result=0 in C1; then done_clr → done=err=0.
- Assert rst_n low during mul cycle 10 → all outputs return to 0. After release, a new add completes normally. Also preload cal_cnt to 0xFFFF via 65535 ops (or a forced value) → the next completion wraps it to 0.
